// File: rtl/match_event_counter.sv
// rtl/match_event_counter.sv - match event counter with threshold interrupt and optional gap measurement
//
// Purpose:
//   Turns the sequence detector's level-held match flag into one-cycle match
//   events, keeps a saturating total match count with a sticky overflow flag,
//   and raises an interrupt once every THRESH matches, held until acknowledged.
//   Optional feature macro: MATCH_GAP_EN (measures cycles between consecutive
//   matches; without it last_gap and gap_valid are tied to 0).
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   det_in       match flag from the detector (level)
//   clr          synchronous clear of counts, flags and interrupt state
//   irq_ack      interrupt acknowledge, honoured only while irq is high
//   match_pulse  one-cycle pulse per match
//   match_count  saturating total match count
//   overflow     sticky, a match arrived with match_count at all-ones
//   irq          interrupt, high while pending
//   last_gap     cycles between the two most recent matches
//   gap_valid    last_gap holds a real measurement

module match_event_counter #(
   parameter int CNT_W  = 16,
   parameter int THRESH = 4,
   parameter int GAP_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det_in,
   input  logic             clr,
   input  logic             irq_ack,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             overflow,
   output logic             irq,
   output logic [GAP_W-1:0] last_gap,
   output logic             gap_valid
);

   localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

   typedef enum logic {IDLE, PEND} state_t;

   state_t           state;
   logic             det_d;
   logic             rise;
   logic [CNT_W-1:0] win_cnt;
   logic [CNT_W-1:0] win_inc;

   assign rise = det_in & ~det_d;

   // Window counter advanced by a rise, saturating at THRESH so that
   // extra matches while pending are not lost and do not wrap.
   assign win_inc = (rise && (win_cnt != THR)) ? win_cnt + CNT_W'(1) : win_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         det_d       <= 1'b0;
         match_pulse <= 1'b0;
         match_count <= '0;
         overflow    <= 1'b0;
         win_cnt     <= '0;
         state       <= IDLE;
         irq         <= 1'b0;
      end else begin
         // Delay line keeps tracking during clr so a run still high after
         // clr is released does not look like a fresh rise.
         det_d <= det_in;
         if (clr) begin
            match_pulse <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
            win_cnt     <= '0;
            state       <= IDLE;
            irq         <= 1'b0;
         end else begin
            match_pulse <= rise;
            if (rise) begin
               if (&match_count) overflow <= 1'b1;
               else              match_count <= match_count + CNT_W'(1);
            end
            case (state)
               IDLE: begin
                  if (win_cnt == THR) begin
                     state   <= PEND;
                     irq     <= 1'b1;
                     win_cnt <= rise ? CNT_W'(1) : '0;
                  end else begin
                     win_cnt <= win_inc;
                  end
               end
               PEND: begin
                  win_cnt <= win_inc;
                  // A full window left behind re-enters PEND from IDLE
                  // on the following cycle.
                  if (irq_ack) begin
                     state <= IDLE;
                     irq   <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef MATCH_GAP_EN
   logic [GAP_W-1:0] gap_cnt;
   logic             seen_first;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         gap_cnt    <= '0;
         seen_first <= 1'b0;
         last_gap   <= '0;
         gap_valid  <= 1'b0;
      end else if (rise) begin
         gap_cnt    <= '0;
         seen_first <= 1'b1;
         // The first rise after reset/clr only starts the measurement.
         if (seen_first) begin
            last_gap  <= (&gap_cnt) ? gap_cnt : gap_cnt + GAP_W'(1);
            gap_valid <= 1'b1;
         end
      end else if (!(&gap_cnt)) begin
         gap_cnt <= gap_cnt + GAP_W'(1);
      end
   end
`else
   assign last_gap  = '0;
   assign gap_valid = 1'b0;
`endif

endmodule
